// File: rtl/acia_pkg.sv
// acia_pkg: shared ACIA state encodings, frame constant and rate helpers
package acia_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int FRAME_BITS = 10;

    function automatic int sym_cnt_of(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int scw_of(input int sym);
        return $clog2(sym);
    endfunction

endpackage

// File: rtl/acia_fifo.sv
// acia_fifo: byte FIFO with wrap-bit pointers, accepts a write while full when a pop happens in the same cycle
module acia_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdat,
    input  logic         i_rd,
    output logic [W-1:0] o_rdat,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic         w_wr_ok;
    logic         w_rd_ok;

    assign o_empty = r_wp == r_rp;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_rd_ok = i_rd && !o_empty;
    assign w_wr_ok = i_wr && (!o_full || w_rd_ok);
    assign o_drop  = i_wr && o_full && !w_rd_ok;
    assign o_rdat  = r_mem[r_rp[AW-1:0]];

    // storage array, written only when the write is accepted
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok)
            r_mem[r_wp[AW-1:0]] <= i_wdat;
    end

    // pointer update; both pointers advance together on a simultaneous write and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr_ok)
                r_wp <= r_wp + (AW+1)'(1);
            if (w_rd_ok)
                r_rp <= r_rp + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/acia_tx.sv
// acia_tx: 8N1 UART transmitter with a small byte FIFO and sticky overflow flag
module acia_tx
    import acia_pkg::*;
#(
    parameter int SCW     = 16,
    parameter int sym_cnt = 40000,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_dat,
    input  logic       tx_stb,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_full,
    output logic       tx_ovf
);
    localparam logic [SCW-1:0] LAST = SCW'(sym_cnt - 1);

    tx_state_e      r_state;
    logic [SCW-1:0] r_cnt;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_serial;
    logic           r_busy;
    logic           r_ovf;
    logic           w_tick;
    logic           w_pop;
    logic           w_line;
    logic [7:0]     w_rdat;
    logic           w_empty;
    logic           w_drop;

    acia_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_wr   (tx_stb),
        .i_wdat (tx_dat),
        .i_rd   (w_pop),
        .o_rdat (w_rdat),
        .o_full (tx_full),
        .o_empty(w_empty),
        .o_drop (w_drop)
    );

    assign w_tick = r_cnt == LAST;
    assign w_pop  = !w_empty && (r_state == TX_IDLE || (r_state == TX_STOP && w_tick));

    // line level implied by the current state; registered below so the pin never glitches
    always_comb begin
        w_line = (r_state == TX_START) ? 1'b0 :
                 (r_state == TX_DATA)  ? r_shift[0] : 1'b1;
    end

    // frame sequencer: pops the FIFO head, steps start/data/stop at the bit rate
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= TX_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_serial <= w_line;
            r_busy   <= (r_state != TX_IDLE) || !w_empty;
            r_cnt    <= (r_state == TX_IDLE || w_tick) ? '0 : r_cnt + SCW'(1);
            case (r_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_rdat;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tick) begin
                        r_bit   <= '0;
                        r_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (w_tick) begin
                        if (w_pop) begin
                            r_shift <= w_rdat;
                            r_state <= TX_START;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    // overflow is sticky until reset
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
    end

    assign tx_serial = r_serial;
    assign tx_busy   = r_busy;
    assign tx_ovf    = r_ovf;

endmodule

// File: tb/tb_acia_tx.sv
// tb_acia_tx: scoreboard bench decoding the serial line and checking bytes, timing and flags
module tb_acia_tx;
    localparam int SYM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_dat = 8'h00;
    logic       tx_stb = 1'b0;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_full;
    logic       tx_ovf;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    int         starts[$];
    logic       skip = 1'b0;

    acia_tx #(.SCW(3), .sym_cnt(SYM), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_dat   (tx_dat),
        .tx_stb   (tx_stb),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy),
        .tx_full  (tx_full),
        .tx_ovf   (tx_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        tx_dat = d;
        tx_stb = 1'b1;
        tick();
        tx_stb = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (q.size() != 0 || tx_busy); i++)
            tick();
        check("drain_q", 32'(q.size()), 32'd0);
        check("drain_busy", 32'(tx_busy), 32'd0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        check("rst_serial", 32'(tx_serial), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_full", 32'(tx_full), 32'd0);
        check("rst_ovf", 32'(tx_ovf), 32'd0);
        rst = 1'b0;
    endtask

    // serial decoder: samples each bit mid-period and retires the scoreboard head
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx_serial === 1'b0) begin
                starts.push_back(cyc);
                for (int i = 0; i < 8; i++) begin
                    repeat (i == 0 ? SYM + 1 : SYM) @(negedge clk);
                    b[i] = tx_serial;
                end
                repeat (SYM) @(negedge clk);
                check("stop_bit", 32'(tx_serial), 32'd1);
                if (skip)
                    skip = 1'b0;
                else if (q.size() == 0)
                    check("unexpected_frame", 32'(q.size()), 32'd1);
                else
                    check("data", 32'(b), 32'(q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tr;
        tick();
        reset_pulse();
        tick();

        // single byte: latency, frame length, busy release
        q.push_back(8'h55);
        strobe(8'h55);
        n = cyc;
        tick();
        check("lat_n1", 32'(tx_serial), 32'd1);
        tick();
        check("lat_n2", 32'(tx_serial), 32'd0);
        while (cyc < n + 41) tick();
        check("busy_n41", 32'(tx_busy), 32'd1);
        tick();
        check("busy_n42", 32'(tx_busy), 32'd0);
        check("idle_line", 32'(tx_serial), 32'd1);
        drain();

        // back-to-back frames with no idle gap
        starts.delete();
        q.push_back(8'hA5);
        q.push_back(8'h3C);
        strobe(8'hA5);
        strobe(8'h3C);
        drain();
        check("b2b_gap", 32'(starts.size() > 1 ? starts[1] - starts[0] : 0), 32'd40);

        // overflow: sixth byte dropped, flag sticky
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) q.push_back(8'(i));
            if (i == 6) check("ovf_before", 32'(tx_ovf), 32'd0);
            strobe(8'(i));
            if (i == 5) check("full_after5", 32'(tx_full), 32'd1);
        end
        check("ovf_set", 32'(tx_ovf), 32'd1);
        drain();
        check("ovf_sticky", 32'(tx_ovf), 32'd1);
        reset_pulse();
        tick();

        // write while full coinciding with the STOP->START pop
        for (int i = 8'h11; i <= 8'h16; i++) q.push_back(8'(i));
        strobe(8'h11);
        n = cyc;
        for (int i = 8'h12; i <= 8'h15; i++) strobe(8'(i));
        check("sim_full", 32'(tx_full), 32'd1);
        while (cyc < n + 40) tick();
        strobe(8'h16);
        check("sim_ovf", 32'(tx_ovf), 32'd0);
        check("sim_full_after", 32'(tx_full), 32'd1);
        drain();
        check("sim_ovf_end", 32'(tx_ovf), 32'd0);

        // reset in the middle of data bit 3 aborts the frame
        skip = 1'b1;
        strobe(8'hFF);
        n = cyc;
        while (cyc < n + 19) tick();
        rst = 1'b1;
        tick();
        check("abort_serial", 32'(tx_serial), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        tr = 0;
        repeat (60) begin
            tick();
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) tr++;
        end
        check("abort_quiet", 32'(tr), 32'd0);
        check("abort_skip_done", 32'(skip), 32'd0);
        q.push_back(8'h5A);
        strobe(8'h5A);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/acia_tx.md
ACIA_TX -- requirements
Module: acia_tx

Interface
REQ-001 Parameter SCW, default 16, width of the symbol-rate counter.
REQ-002 Parameter sym_cnt, default 40000 (48 MHz / 1200 baud), clocks per serial bit.
REQ-003 Parameter DEPTH, default 4, transmit FIFO depth in bytes; the value SHALL be a power of 2, with a minimum of 2.
REQ-004 clk  input  1  system clock; the block SHALL use one clock only, and all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset; it SHALL be synchronous and active-high.
REQ-006 tx_dat  input  8  byte to enqueue; it SHALL be sampled only when tx_stb=1.
REQ-007 tx_stb  input  1  single-cycle write strobe.
REQ-008 tx_serial  output  1  UART line; its idle level SHALL be 1.
REQ-009 tx_busy  output  1  SHALL be 1 while a frame is in flight or the FIFO is non-empty.
REQ-010 tx_full  output  1  SHALL be 1 when the FIFO holds DEPTH entries.
REQ-011 tx_ovf  output  1  sticky flag; it SHALL set when a write is dropped.

Function
REQ-012 Frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
REQ-013 Each bit SHALL last exactly sym_cnt clocks; a full frame SHALL last 10*sym_cnt clocks.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 In IDLE with the FIFO non-empty, the block SHALL pop the head byte into the shift register and enter START.
REQ-016 START SHALL move to DATA after sym_cnt clocks.
REQ-017 DATA SHALL shift one bit per sym_cnt clocks and move to STOP after bit 7.
REQ-018 STOP SHALL last sym_cnt clocks, then:
- if the FIFO is non-empty, the block SHALL pop and enter START directly, with no idle gap between frames;
- otherwise it SHALL enter IDLE.
REQ-019 Latency: for a strobe at edge N with the FIFO empty and the FSM in IDLE, tx_serial SHALL go to 0 at edge N+2.
REQ-020 tx_serial SHALL be driven from a register, so it is glitch-free.
REQ-021 A write with tx_full=1 and no pop in the same cycle SHALL be discarded: FIFO contents unchanged, tx_ovf set to 1.
REQ-022 A write and a pop in the same cycle SHALL both take effect, including when the FIFO is full; occupancy is then unchanged.
REQ-023 FIFO pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full and empty SHALL be derived from MSB/LSB pointer comparison.
REQ-024 The bit counter SHALL be 3 bits; the rate counter SHALL be SCW bits, counting 0..sym_cnt-1 and then wrapping to 0.
REQ-025 tx_ovf SHALL clear only on rst.

Reset
REQ-026 With rst=1 at an edge, the following SHALL hold after that edge: tx_serial=1, tx_busy=0, tx_full=0, tx_ovf=0, FSM=IDLE, FIFO empty, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately; the line SHALL return high on the next edge and no partial byte SHALL be resumed.
REQ-028 tx_stb SHALL be ignored while rst=1.

Structure
REQ-029 FSM state encodings and the frame-length constant (10 bits) SHALL reside in the shared acia include/package, alongside the receiver's definitions.
REQ-030 The FIFO SHALL be a separate sub-module, acia_fifo (parameters DEPTH, width 8), reusable by the receive path.
REQ-031 The top level SHALL instantiate acia_tx with the same SCW/sym_cnt derivation as the receiver, with tx_serial driving fpga_tx.

Verification (sym_cnt=4, SCW=3, DEPTH=4 unless noted)
REQ-032 Single byte: 0x55 strobed at edge 10 -> tx_serial=0 over edges 12-15, then 1,0,1,0,1,0,1,0 at 4 clocks per bit, stop=1 over edges 48-51; tx_busy deasserts at edge 52.
REQ-033 Back-to-back: 0xA5 then 0x3C strobed on consecutive cycles -> two frames with no idle gap; the second start bit begins exactly 40 clocks after the first.
REQ-034 Overflow: 6 consecutive strobes (0x01..0x06) while idle -> 0x01 is popped, 0x02-0x05 fill the FIFO, and 0x06 is dropped; tx_ovf=1; 0x01..0x05 are transmitted in order.
REQ-035 Simultaneous: write while full in the same cycle as the STOP->START pop -> write accepted, tx_ovf stays 0, order preserved.
REQ-036 Reset mid-frame: rst pulsed during DATA bit 3 of 0xFF -> tx_serial=1 on the next edge, tx_busy=0, and no further transitions until a new strobe.
REQ-037 Default parameters: one byte 0x41 -> measured bit period 40000 clocks and frame length 400000 clocks.
